// File: rtl/bip_ram_arbiter.sv
// Arbiter sharing the BIP I data RAM between the CPU control unit (C) and the
// debug unit (D); registers the winning access and routes read returns back.
module bip_ram_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              C_Req,
    input  logic              C_We,
    input  logic [ADDR_W-1:0] C_Addr,
    input  logic [DATA_W-1:0] C_WData,
    output logic              C_Gnt,
    output logic              C_RValid,
    input  logic              D_Req,
    input  logic              D_We,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic [DATA_W-1:0] D_WData,
    output logic              D_Gnt,
    output logic              D_RValid,
    input  logic              D_Lock,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] Ram_Addr,
    output logic [DATA_W-1:0] Ram_WData,
    output logic              Ram_Rd,
    output logic              Ram_Wr,
    input  logic [DATA_W-1:0] Ram_RData
);

    typedef enum logic {ST_ARB, ST_LOCK} state_e;
    localparam logic OWN_C = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_e            state_q;
    logic              last_q;
    logic              gnt_c, gnt_d;
    logic              issue, iss_we, iss_rd;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_W-1:0] iss_wdata;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_q, wr_q;
    logic [RD_LAT:0]   tag_vld_q, tag_own_q;

    // Grants are combinational so a requester can issue in its request cycle.
    always_comb begin
        gnt_c = 1'b0;
        gnt_d = 1'b0;
        if (Reset) begin
            if (state_q == ST_LOCK && D_Lock) begin
                gnt_d = D_Req;
            end else if (state_q == ST_LOCK) begin
                // Leaving lock hands priority straight back to the CPU.
                gnt_c = C_Req;
                gnt_d = D_Req & ~C_Req;
            end else if (C_Req && D_Req) begin
                gnt_c = (last_q == OWN_D);
                gnt_d = (last_q == OWN_C);
            end else begin
                gnt_c = C_Req;
                gnt_d = D_Req;
            end
        end
    end

    assign issue     = gnt_c | gnt_d;
    assign iss_we    = gnt_c ? C_We    : D_We;
    assign iss_addr  = gnt_c ? C_Addr  : D_Addr;
    assign iss_wdata = gnt_c ? C_WData : D_WData;
    assign iss_rd    = issue & ~iss_we;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_ARB;
            last_q  <= OWN_D;
        end else begin
            if (gnt_c)      last_q <= OWN_C;
            else if (gnt_d) last_q <= OWN_D;
            case (state_q)
                ST_ARB:  if (gnt_d && D_Lock) state_q <= ST_LOCK;
                ST_LOCK: if (!D_Lock)         state_q <= ST_ARB;
                default:                      state_q <= ST_ARB;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            rd_q <= iss_rd;
            wr_q <= issue & iss_we;
            if (issue) begin
                addr_q  <= iss_addr;
                wdata_q <= iss_wdata;
            end
        end
    end

    // Tag stage k is valid k+1 cycles after the issue; the last stage lines up
    // with Ram_RData for the registered read RD_LAT cycles earlier.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[RD_LAT-1:0], iss_rd};
            tag_own_q <= {tag_own_q[RD_LAT-1:0], gnt_d};
        end
    end

    assign C_Gnt     = gnt_c;
    assign D_Gnt     = gnt_d;
    assign C_RValid  = Reset & tag_vld_q[RD_LAT] & (tag_own_q[RD_LAT] == OWN_C);
    assign D_RValid  = Reset & tag_vld_q[RD_LAT] & (tag_own_q[RD_LAT] == OWN_D);
    assign RData     = Ram_RData;
    assign Ram_Addr  = addr_q;
    assign Ram_WData = wdata_q;
    assign Ram_Rd    = rd_q;
    assign Ram_Wr    = wr_q;

endmodule

// File: tb/tb_bip_ram_arbiter.sv
// Bench for bip_ram_arbiter: three instances (RD_LAT 1..3) share stimulus and
// are scored against a queue-based reference model plus directed scenarios.
module tb_bip_ram_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int NL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, c_req, c_we, d_req, d_we, d_lock;
  logic [AW-1:0] c_addr, d_addr;
  logic [DW-1:0] c_wdata, d_wdata;
  logic c_gnt [NL], d_gnt [NL], c_rv [NL], d_rv [NL], ram_rd [NL], ram_wr [NL];
  logic [DW-1:0] rdata [NL], ram_wdata [NL], ram_rdata [NL];
  logic [AW-1:0] ram_addr [NL];

  function automatic logic [DW-1:0] init_val(int a);
    if (a == 5) return 16'h1234;
    return 16'(a * 257) ^ 16'h5A5A;
  endfunction

  for (genvar g = 0; g < NL; g++) begin : g_lat
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] dly [0:g];
    initial for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val(i);
    always @(posedge clk) begin
      if (ram_wr[g]) mem[ram_addr[g]] <= ram_wdata[g];
      dly[0] <= mem[ram_addr[g]];
      for (int k = 1; k <= g; k++) dly[k] <= dly[k-1];
    end
    assign ram_rdata[g] = dly[g];

    bip_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(g+1)) dut (
      .Clk(clk), .Reset(rst_n),
      .C_Req(c_req), .C_We(c_we), .C_Addr(c_addr), .C_WData(c_wdata),
      .C_Gnt(c_gnt[g]), .C_RValid(c_rv[g]),
      .D_Req(d_req), .D_We(d_we), .D_Addr(d_addr), .D_WData(d_wdata),
      .D_Gnt(d_gnt[g]), .D_RValid(d_rv[g]), .D_Lock(d_lock),
      .RData(rdata[g]), .Ram_Addr(ram_addr[g]), .Ram_WData(ram_wdata[g]),
      .Ram_Rd(ram_rd[g]), .Ram_Wr(ram_wr[g]), .Ram_RData(ram_rdata[g]));
  end

  // Reference model: lock/last ownership, expected RAM strobes, and a queue of
  // pending read returns per latency with the data value at issue time.
  typedef struct { int due; int lat; bit own; logic [DW-1:0] data; } ret_t;
  ret_t retq [$];
  bit m_lock, m_last, e_gc, e_gd;
  logic e_rd, e_wr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  int cyc, n_checks, n_fail;

  task automatic sample();
    logic ecv [NL];
    logic edv [NL];
    logic [DW-1:0] ed [NL];
    @(negedge clk);
    e_gc = 1'b0; e_gd = 1'b0;
    if (rst_n) begin
      if (m_lock && d_lock) e_gd = d_req;
      else if (m_lock) begin e_gc = c_req; e_gd = d_req && !c_req; end
      else if (c_req && d_req) begin e_gc = m_last; e_gd = !m_last; end
      else begin e_gc = c_req; e_gd = d_req; end
    end
    for (int g = 0; g < NL; g++) begin ecv[g] = 1'b0; edv[g] = 1'b0; ed[g] = '0; end
    foreach (retq[j]) if (retq[j].due == cyc && rst_n) begin
      if (retq[j].own) edv[retq[j].lat] = 1'b1; else ecv[retq[j].lat] = 1'b1;
      ed[retq[j].lat] = retq[j].data;
    end
    for (int g = 0; g < NL; g++) begin
      n_checks++;
      if (c_gnt[g] !== e_gc) begin n_fail++; $display("FAIL sb_c_gnt lat%0d cyc%0d got %b exp %b", g+1, cyc, c_gnt[g], e_gc); end
      n_checks++;
      if (d_gnt[g] !== e_gd) begin n_fail++; $display("FAIL sb_d_gnt lat%0d cyc%0d got %b exp %b", g+1, cyc, d_gnt[g], e_gd); end
      n_checks++;
      if (ram_rd[g] !== e_rd) begin n_fail++; $display("FAIL sb_ram_rd lat%0d cyc%0d got %b exp %b", g+1, cyc, ram_rd[g], e_rd); end
      n_checks++;
      if (ram_wr[g] !== e_wr) begin n_fail++; $display("FAIL sb_ram_wr lat%0d cyc%0d got %b exp %b", g+1, cyc, ram_wr[g], e_wr); end
      n_checks++;
      if (ram_addr[g] !== e_addr) begin n_fail++; $display("FAIL sb_ram_addr lat%0d cyc%0d got %h exp %h", g+1, cyc, ram_addr[g], e_addr); end
      n_checks++;
      if (ram_wdata[g] !== e_wdata) begin n_fail++; $display("FAIL sb_ram_wdata lat%0d cyc%0d got %h exp %h", g+1, cyc, ram_wdata[g], e_wdata); end
      n_checks++;
      if (c_rv[g] !== ecv[g]) begin n_fail++; $display("FAIL sb_c_rvalid lat%0d cyc%0d got %b exp %b", g+1, cyc, c_rv[g], ecv[g]); end
      n_checks++;
      if (d_rv[g] !== edv[g]) begin n_fail++; $display("FAIL sb_d_rvalid lat%0d cyc%0d got %b exp %b", g+1, cyc, d_rv[g], edv[g]); end
      if (ecv[g] || edv[g]) begin
        n_checks++;
        if (rdata[g] !== ed[g]) begin n_fail++; $display("FAIL sb_rdata lat%0d cyc%0d got %h exp %h", g+1, cyc, rdata[g], ed[g]); end
      end
    end
  endtask

  task automatic adv();
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    if (!rst_n) begin
      m_lock = 1'b0; m_last = 1'b1;
      e_rd = 1'b0; e_wr = 1'b0; e_addr = '0; e_wdata = '0;
      retq.delete();
    end else begin
      we = e_gc ? c_we : d_we;
      a  = e_gc ? c_addr : d_addr;
      wd = e_gc ? c_wdata : d_wdata;
      e_rd = (e_gc || e_gd) && !we;
      e_wr = (e_gc || e_gd) && we;
      if (e_gc || e_gd) begin
        e_addr = a; e_wdata = wd;
        if (we) mmem[a] = wd;
        else for (int g = 0; g < NL; g++)
          retq.push_back('{due: cyc + 2 + g, lat: g, own: e_gd, data: mmem[a]});
      end
      m_lock = m_lock ? d_lock : (e_gd && d_lock);
      if (e_gc) m_last = 1'b0; else if (e_gd) m_last = 1'b1;
      for (int j = retq.size() - 1; j >= 0; j--) if (retq[j].due <= cyc) retq.delete(j);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic clr_in();
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_lock = 0;
  endtask

  task automatic idle(int n);
    clr_in();
    repeat (n) begin sample(); adv(); end
  endtask

  task automatic test_reset();
    clr_in(); rst_n = 0;
    repeat (2) begin sample(); adv(); end
    sample();
    n_checks++;
    if ({c_gnt[0], d_gnt[0], c_rv[0], d_rv[0], ram_rd[0], ram_wr[0]} !== 6'b0 || ram_addr[0] !== '0 || ram_wdata[0] !== '0) begin
      n_fail++; $display("FAIL reset_outputs got gnt=%b%b rv=%b%b rd=%b wr=%b addr=%h wd=%h exp all zero",
        c_gnt[0], d_gnt[0], c_rv[0], d_rv[0], ram_rd[0], ram_wr[0], ram_addr[0], ram_wdata[0]);
    end
    adv(); rst_n = 1;
    c_req = 1; c_we = 0; c_addr = 11'd5;
    sample();
    n_checks++;
    if (c_gnt[0] !== 1'b1 || d_gnt[0] !== 1'b0) begin n_fail++; $display("FAIL first_read_gnt got c=%b d=%b exp c=1 d=0", c_gnt[0], d_gnt[0]); end
    adv(); c_req = 0;
    sample();
    n_checks++;
    if (ram_rd[0] !== 1'b1 || ram_wr[0] !== 1'b0 || ram_addr[0] !== 11'd5) begin
      n_fail++; $display("FAIL first_read_strobe got rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=005", ram_rd[0], ram_wr[0], ram_addr[0]);
    end
    adv();
    sample();
    n_checks++;
    if (c_rv[0] !== 1'b1 || d_rv[0] !== 1'b0 || rdata[0] !== 16'h1234) begin
      n_fail++; $display("FAIL first_read_data got crv=%b drv=%b data=%h exp crv=1 drv=0 data=1234", c_rv[0], d_rv[0], rdata[0]);
    end
    adv();
    idle(4);
  endtask

  task automatic test_contention();
    clr_in(); rst_n = 0; sample(); adv(); rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      c_req = (i < 4); d_req = (i < 4); c_we = 0; d_we = 0;
      c_addr = AW'(i); d_addr = AW'(16 + i);
      sample();
      if (i < 4) begin
        n_checks++;
        if (c_gnt[0] !== (i % 2 == 0) || d_gnt[0] !== (i % 2 == 1)) begin
          n_fail++; $display("FAIL contention_gnt i=%0d got c=%b d=%b exp c=%b d=%b", i, c_gnt[0], d_gnt[0], i % 2 == 0, i % 2 == 1);
        end
      end
      if (i >= 2 && i <= 5) begin
        n_checks++;
        if (c_rv[0] !== ((i - 2) % 2 == 0) || d_rv[0] !== ((i - 2) % 2 == 1) ||
            rdata[0] !== (((i - 2) % 2 == 0) ? init_val(i - 2) : init_val(16 + i - 2))) begin
          n_fail++; $display("FAIL contention_rvalid i=%0d got c=%b d=%b data=%h", i, c_rv[0], d_rv[0], rdata[0]);
        end
      end
      adv();
    end
    idle(3);
  endtask

  task automatic test_write_readback();
    clr_in();
    d_req = 1; d_we = 1; d_addr = 11'h7FF; d_wdata = 16'hBEEF;
    sample();
    n_checks++;
    if (d_gnt[0] !== 1'b1) begin n_fail++; $display("FAIL wr_gnt got %b exp 1", d_gnt[0]); end
    adv(); d_we = 0;
    sample();
    n_checks++;
    if (ram_wr[0] !== 1'b1 || ram_rd[0] !== 1'b0 || ram_addr[0] !== 11'h7FF || ram_wdata[0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL wr_strobe got wr=%b rd=%b addr=%h wd=%h exp wr=1 rd=0 addr=7ff wd=beef", ram_wr[0], ram_rd[0], ram_addr[0], ram_wdata[0]);
    end
    adv(); clr_in();
    sample();
    n_checks++;
    if (ram_wr[0] !== 1'b0 || ram_rd[0] !== 1'b1 || d_rv[0] !== 1'b0) begin
      n_fail++; $display("FAIL wr_single_cycle got wr=%b rd=%b drv=%b exp wr=0 rd=1 drv=0", ram_wr[0], ram_rd[0], d_rv[0]);
    end
    adv();
    sample();
    n_checks++;
    if (d_rv[0] !== 1'b1 || c_rv[0] !== 1'b0 || rdata[0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL readback got drv=%b crv=%b data=%h exp drv=1 crv=0 data=beef", d_rv[0], c_rv[0], rdata[0]);
    end
    adv();
    idle(4);
  endtask

  task automatic test_lock();
    clr_in();
    d_req = 1; d_lock = 1; d_addr = 11'h100;
    sample();
    n_checks++;
    if (d_gnt[0] !== 1'b1) begin n_fail++; $display("FAIL lock_enter got d_gnt=%b exp 1", d_gnt[0]); end
    adv();
    for (int i = 1; i <= 3; i++) begin
      c_req = 1; c_addr = 11'h020; d_req = (i != 2); d_addr = AW'(256 + i);
      sample();
      n_checks++;
      if (c_gnt[0] !== 1'b0 || d_gnt[0] !== (i != 2)) begin
        n_fail++; $display("FAIL lock_hold i=%0d got c=%b d=%b exp c=0 d=%b", i, c_gnt[0], d_gnt[0], i != 2);
      end
      adv();
    end
    d_lock = 0; d_req = 1;
    sample();
    n_checks++;
    if (c_gnt[0] !== 1'b1 || d_gnt[0] !== 1'b0) begin n_fail++; $display("FAIL lock_release got c=%b d=%b exp c=1 d=0", c_gnt[0], d_gnt[0]); end
    adv();
    idle(4);
  endtask

  task automatic test_reset_mid_read();
    clr_in();
    c_req = 1; c_addr = 11'h030;
    sample();
    n_checks++;
    if (c_gnt[2] !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt got %b exp 1", c_gnt[2]); end
    adv(); clr_in();
    sample(); adv();
    rst_n = 0; c_req = 1; c_we = 1; c_addr = 11'h200; c_wdata = 16'hA5A5;
    sample();
    n_checks++;
    if (c_gnt[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_gnt_gated got %b exp 0", c_gnt[2]); end
    adv(); rst_n = 1;
    sample();
    n_checks++;
    if (ram_rd[2] !== 1'b0 || ram_wr[2] !== 1'b0 || ram_addr[2] !== '0) begin
      n_fail++; $display("FAIL midrst_strobes got rd=%b wr=%b addr=%h exp 0 0 000", ram_rd[2], ram_wr[2], ram_addr[2]);
    end
    adv(); clr_in();
    for (int k = 0; k < 4; k++) begin
      sample();
      n_checks++;
      if (c_rv[2] !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rvalid k=%0d got %b exp 0", k, c_rv[2]); end
      adv();
    end
  endtask

  task automatic test_pipeline_lat2();
    clr_in();
    for (int i = 0; i < 10; i++) begin
      c_req = (i < 4); c_we = 0; c_addr = AW'(i);
      sample();
      if (i < 4) begin
        n_checks++;
        if (c_gnt[1] !== 1'b1) begin n_fail++; $display("FAIL pipe_gnt i=%0d got %b exp 1", i, c_gnt[1]); end
      end
      n_checks++;
      if (c_rv[1] !== (i >= 3 && i <= 6)) begin n_fail++; $display("FAIL pipe_rvalid i=%0d got %b exp %b", i, c_rv[1], i >= 3 && i <= 6); end
      if (i >= 3 && i <= 6) begin
        n_checks++;
        if (rdata[1] !== init_val(i - 3)) begin n_fail++; $display("FAIL pipe_data i=%0d got %h exp %h", i, rdata[1], init_val(i - 3)); end
      end
      adv();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n   = ($urandom_range(0, 63) != 0);
      c_req   = 1'($urandom_range(0, 1));
      d_req   = 1'($urandom_range(0, 1));
      c_we    = ($urandom_range(0, 3) == 0);
      d_we    = ($urandom_range(0, 3) == 0);
      d_lock  = ($urandom_range(0, 3) == 0);
      c_addr  = AW'($urandom_range(0, 2047));
      d_addr  = AW'($urandom_range(0, 2047));
      c_wdata = DW'($urandom);
      d_wdata = DW'($urandom);
      sample(); adv();
    end
    rst_n = 1;
    idle(6);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    m_lock = 0; m_last = 1; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
    for (int i = 0; i < (1<<AW); i++) mmem[i] = init_val(i);
    rst_n = 0; clr_in();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_contention();
    test_write_readback();
    test_lock();
    test_reset_mid_read();
    test_pipeline_lat2();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
